// File: rtl/convertidor_32a8.sv
// convertidor_32a8: serializes 1/2/4-byte words into an LSB-first byte stream
module convertidor_32a8 (
  input  logic        CLK,
  input  logic        ENB,
  input  logic [1:0]  PCLK,
  input  logic [31:0] IN_DATA,
  input  logic        IN_VALID,
  output logic        IN_READY,
  output logic [7:0]  OUT_DATA,
  output logic        OUT_VALID,
  output logic [1:0]  BIT
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t      state_q, state_d;
  logic [31:0] shreg_q, shreg_d;
  logic [2:0]  rem_q, rem_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic [1:0]  bit_q, bit_d;
  logic        accept;
  logic [2:0]  size;
  assign IN_READY = (state_q == IDLE) | (state_q == SEND & rem_q == 3'd1);
  assign accept   = IN_VALID & IN_READY;
  assign size     = (PCLK == 2'b00) ? 3'd1 : (PCLK == 2'b01) ? 3'd2 : 3'd4;
  // rem_q counts bytes still owed, including the one currently on OUT_DATA
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    rem_d   = rem_q;
    data_d  = data_q;
    valid_d = valid_q;
    bit_d   = bit_q;
    if (accept) begin
      state_d = SEND;
      data_d  = IN_DATA[7:0];
      shreg_d = {8'h00, IN_DATA[31:8]};
      rem_d   = size;
      bit_d   = 2'd0;
      valid_d = 1'b1;
    end else if (state_q == SEND && rem_q > 3'd1) begin
      data_d  = shreg_q[7:0];
      shreg_d = shreg_q >> 8;
      rem_d   = rem_q - 3'd1;
      bit_d   = bit_q + 2'd1;
    end else begin
      state_d = IDLE;
      shreg_d = 32'h0;
      rem_d   = 3'd0;
      data_d  = 8'h00;
      valid_d = 1'b0;
      bit_d   = 2'd0;
    end
  end
  always_ff @(posedge CLK) begin
    if (!ENB) begin
      state_q <= IDLE;
      shreg_q <= 32'h0;
      rem_q   <= 3'd0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      bit_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      bit_q   <= bit_d;
    end
  end
  assign OUT_DATA  = data_q;
  assign OUT_VALID = valid_q;
  assign BIT       = bit_q;
endmodule

// File: tb/tb_convertidor_32a8.sv
// tb_convertidor_32a8: directed checks of the 32-to-8 serializer
module tb_convertidor_32a8;
  logic        CLK = 1'b0;
  logic        ENB = 1'b0;
  logic [1:0]  PCLK = 2'b00;
  logic [31:0] IN_DATA = 32'h0;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [7:0]  OUT_DATA;
  logic        OUT_VALID;
  logic [1:0]  BIT;
  int checks = 0;
  int errors = 0;
  convertidor_32a8 dut (
    .CLK(CLK), .ENB(ENB), .PCLK(PCLK), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID),
    .IN_READY(IN_READY), .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .BIT(BIT)
  );
  always #5 CLK = ~CLK;
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] b, input logic r);
    chk({tag, ".valid"}, {31'h0, OUT_VALID}, {31'h0, v});
    chk({tag, ".data"}, {24'h0, OUT_DATA}, {24'h0, d});
    chk({tag, ".bit"}, {30'h0, BIT}, {30'h0, b});
    chk({tag, ".ready"}, {31'h0, IN_READY}, {31'h0, r});
  endtask
  initial begin
    ENB = 1'b0; IN_VALID = 1'b1; PCLK = 2'b10; IN_DATA = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst.valid", {31'h0, OUT_VALID}, 32'h0);
      chk("rst.data", {24'h0, OUT_DATA}, 32'h0);
      chk("rst.bit", {30'h0, BIT}, 32'h0);
    end
    IN_VALID = 1'b0; ENB = 1'b1;
    chk("rst.ready", {31'h0, IN_READY}, 32'h1);
    tick();
    out("idle", 0, 8'h00, 0, 1);
    IN_VALID = 1'b1; PCLK = 2'b10; IN_DATA = 32'hA1B2C3D4;
    tick(); IN_VALID = 1'b0;
    out("w32.b0", 1, 8'hD4, 0, 0);
    tick(); out("w32.b1", 1, 8'hC3, 1, 0);
    tick(); out("w32.b2", 1, 8'hB2, 2, 0);
    tick(); out("w32.b3", 1, 8'hA1, 3, 1);
    tick(); out("w32.end", 0, 8'h00, 0, 1);
    IN_VALID = 1'b1; IN_DATA = 32'h11223344;
    tick(); IN_DATA = 32'h55667788;
    out("b2b.b0", 1, 8'h44, 0, 0);
    tick(); out("b2b.b1", 1, 8'h33, 1, 0);
    tick(); out("b2b.b2", 1, 8'h22, 2, 0);
    tick(); out("b2b.b3", 1, 8'h11, 3, 1);
    tick(); IN_VALID = 1'b0;
    out("b2b.b4", 1, 8'h88, 0, 0);
    tick(); out("b2b.b5", 1, 8'h77, 1, 0);
    tick(); out("b2b.b6", 1, 8'h66, 2, 0);
    tick(); out("b2b.b7", 1, 8'h55, 3, 1);
    tick(); out("b2b.end", 0, 8'h00, 0, 1);
    IN_VALID = 1'b1; PCLK = 2'b00; IN_DATA = 32'h000000AB;
    tick(); PCLK = 2'b01; IN_DATA = 32'h0000CDEF;
    out("mix.ab", 1, 8'hAB, 0, 1);
    tick(); out("mix.ef", 1, 8'hEF, 0, 0);
    tick(); PCLK = 2'b11; IN_DATA = 32'h01020304;
    out("mix.cd", 1, 8'hCD, 1, 1);
    tick(); IN_VALID = 1'b0;
    out("mix.04", 1, 8'h04, 0, 0);
    tick(); out("mix.03", 1, 8'h03, 1, 0);
    tick(); out("mix.02", 1, 8'h02, 2, 0);
    tick(); out("mix.01", 1, 8'h01, 3, 1);
    tick(); out("mix.end", 0, 8'h00, 0, 1);
    IN_VALID = 1'b1; PCLK = 2'b00; IN_DATA = 32'hFFFFFF5A;
    tick(); IN_VALID = 1'b0;
    out("one.5a", 1, 8'h5A, 0, 1);
    tick(); out("one.end", 0, 8'h00, 0, 1);
    IN_VALID = 1'b1; PCLK = 2'b10; IN_DATA = 32'h12345678;
    tick(); IN_VALID = 1'b0; PCLK = 2'b00;
    out("pclk.b0", 1, 8'h78, 0, 0);
    tick(); out("pclk.b1", 1, 8'h56, 1, 0);
    tick(); out("pclk.b2", 1, 8'h34, 2, 0);
    tick(); out("pclk.b3", 1, 8'h12, 3, 1);
    tick(); out("pclk.end", 0, 8'h00, 0, 1);
    IN_VALID = 1'b1; PCLK = 2'b10; IN_DATA = 32'hDEADBEEF;
    tick(); IN_VALID = 1'b0;
    out("mrst.b0", 1, 8'hEF, 0, 0);
    tick(); out("mrst.b1", 1, 8'hBE, 1, 0);
    ENB = 1'b0;
    tick(); ENB = 1'b1;
    out("mrst.cut", 0, 8'h00, 0, 1);
    tick(); out("mrst.after", 0, 8'h00, 0, 1);
    tick(); out("mrst.after2", 0, 8'h00, 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
